// File: rtl/div_seq.sv
// Sequential restoring divider: out_width-bit dividend / in_width-bit divisor, one quotient bit per clock.
// Fixed latency of out_width+2 edges; results are held until the next completed operation.
module div_seq #(
    parameter int in_width  = 4,
    parameter int out_width = in_width * 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [out_width-1:0] data_dividend,
    input  logic [in_width-1:0]  data_divisor,
    input  logic                 ctrl_enable,
    output logic [out_width-1:0] data_quotient,
    output logic [in_width-1:0]  data_remainder,
    output logic                 ctrl_done,
    output logic                 ctrl_err
);
    localparam int CW = (out_width > 1) ? $clog2(out_width) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [out_width-1:0]   dvd_q, dvd_d;
    logic [in_width-1:0]    dvd_lo_q, dvd_lo_d;
    logic [in_width-1:0]    dvs_q, dvs_d;
    logic [in_width:0]      rem_q, rem_d;
    logic [out_width-1:0]   quo_q, quo_d;
    logic [out_width-1:0]   quotient_q, quotient_d;
    logic [in_width-1:0]    remainder_q, remainder_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;

    logic [in_width:0]      rem_shift, rem_diff, rem_next;
    logic                   q_bit;
    logic [out_width-1:0]   quo_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem_q[in_width-1:0], dvd_q[out_width-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        q_bit     = (rem_shift >= {1'b0, dvs_q});
        rem_next  = q_bit ? rem_diff : rem_shift;
        quo_next  = {quo_q[out_width-2:0], q_bit};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvd_lo_d    = dvd_lo_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        err_d       = err_q;
        done_d      = done_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (ctrl_enable) state_d = LOAD;
            end
            LOAD: begin
                if (!ctrl_enable) begin
                    state_d = IDLE;
                end else begin
                    dvd_d    = data_dividend;
                    dvd_lo_d = data_dividend[in_width-1:0];
                    dvs_d    = data_divisor;
                    rem_d    = '0;
                    quo_d    = '0;
                    cnt_d    = CW'(out_width - 1);
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (!ctrl_enable) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_next;
                    dvd_d = {dvd_q[out_width-2:0], 1'b0};
                    quo_d = quo_next;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        // Divide-by-zero runs the full latency, then overrides the result.
                        if (dvs_q == '0) begin
                            quotient_d  = '1;
                            remainder_d = dvd_lo_q;
                            err_d       = 1'b1;
                        end else begin
                            quotient_d  = quo_next;
                            remainder_d = rem_next[in_width-1:0];
                            err_d       = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            DONE: begin
                if (!ctrl_enable) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvd_lo_q    <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvd_lo_q    <= dvd_lo_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign data_quotient  = quotient_q;
    assign data_remainder = remainder_q;
    assign ctrl_done      = done_q;
    assign ctrl_err       = err_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: hand-computed vectors, abort, async reset and a full operand sweep.
module tb_div_seq;
    logic       clk;
    logic       rst;
    logic [7:0] data_dividend;
    logic [3:0] data_divisor;
    logic       ctrl_enable;
    logic [7:0] data_quotient;
    logic [3:0] data_remainder;
    logic       ctrl_done;
    logic       ctrl_err;

    int checks = 0;
    int errors = 0;

    div_seq #(.in_width(4), .out_width(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_dividend  (data_dividend),
        .data_divisor   (data_divisor),
        .ctrl_enable    (ctrl_enable),
        .data_quotient  (data_quotient),
        .data_remainder (data_remainder),
        .ctrl_done      (ctrl_done),
        .ctrl_err       (ctrl_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one operation against hand-supplied expected results; called at a negedge.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er, input logic ee,
                          input int hold);
        int lat;
        data_dividend = a;
        data_divisor  = b;
        ctrl_enable   = 1'b1;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            cyc();
            if (ctrl_done) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 10);
        chk({tag, "_q"}, {24'd0, data_quotient}, {24'd0, eq});
        chk({tag, "_r"}, {28'd0, data_remainder}, {28'd0, er});
        chk({tag, "_err"}, {31'd0, ctrl_err}, {31'd0, ee});
        for (int h = 0; h < hold; h++) begin
            data_dividend = ~a;
            data_divisor  = b + 4'd1;
            cyc();
            chk({tag, "_done_held"}, {31'd0, ctrl_done}, 32'd1);
            chk({tag, "_q_held"}, {24'd0, data_quotient}, {24'd0, eq});
        end
        ctrl_enable = 1'b0;
        cyc();
        chk({tag, "_done_low"}, {31'd0, ctrl_done}, 32'd0);
        chk({tag, "_r_kept"}, {28'd0, data_remainder}, {28'd0, er});
    endtask

    initial begin
        logic [7:0] eq;
        logic [3:0] er;
        rst           = 1'b0;
        ctrl_enable   = 1'b0;
        data_dividend = 8'd0;
        data_divisor  = 4'd0;
        cyc();
        cyc();
        chk("reset_q", {24'd0, data_quotient}, 32'd0);
        chk("reset_r", {28'd0, data_remainder}, 32'd0);
        chk("reset_done", {31'd0, ctrl_done}, 32'd0);
        chk("reset_err", {31'd0, ctrl_err}, 32'd0);
        rst = 1'b1;
        cyc();

        run_op("d100_7", 8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 3);
        run_op("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 1);
        run_op("d5_9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 1);
        run_op("d3c_0", 8'h3C, 4'd0, 8'hFF, 4'hC, 1'b1, 2);
        run_op("d3c_4", 8'h3C, 4'd4, 8'd15, 4'd0, 1'b0, 1);

        // Abort during the 4th CALC step: enable falls before edge E0+5.
        data_dividend = 8'd200;
        data_divisor  = 4'd3;
        ctrl_enable   = 1'b1;
        for (int n = 0; n < 5; n++) cyc();
        ctrl_enable = 1'b0;
        for (int n = 0; n < 12; n++) begin
            cyc();
            chk("abort_done", {31'd0, ctrl_done}, 32'd0);
        end
        chk("abort_q_kept", {24'd0, data_quotient}, 32'd15);
        chk("abort_r_kept", {28'd0, data_remainder}, 32'd0);
        chk("abort_err_kept", {31'd0, ctrl_err}, 32'd0);
        run_op("d200_3", 8'd200, 4'd3, 8'd66, 4'd2, 1'b0, 1);

        // Asynchronous reset mid-CALC, away from any clock edge.
        data_dividend = 8'd123;
        data_divisor  = 4'd4;
        ctrl_enable   = 1'b1;
        for (int n = 0; n < 5; n++) cyc();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_q", {24'd0, data_quotient}, 32'd0);
        chk("arst_r", {28'd0, data_remainder}, 32'd0);
        chk("arst_done", {31'd0, ctrl_done}, 32'd0);
        chk("arst_err", {31'd0, ctrl_err}, 32'd0);
        ctrl_enable = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        run_op("d77_5", 8'd77, 4'd5, 8'd15, 4'd2, 1'b0, 1);

        // Full operand sweep against integer division.
        for (int b = 0; b < 16; b++) begin
            for (int a = 0; a < 256; a++) begin
                if (b == 0) begin
                    eq = 8'hFF;
                    er = 4'(a);
                end else begin
                    eq = 8'(a / b);
                    er = 4'(a % b);
                end
                run_op("sweep", 8'(a), 4'(b), eq, er, (b == 0), 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
